// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// WIDTH iterations plus one sign-fix cycle. MTHI/MTLO write HI/LO directly from idle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q;
    logic [CW-1:0]      count_q;
    logic               is_div_q;
    logic               neg_lo_q;   // negate product / quotient at fix
    logic               neg_hi_q;   // negate remainder at fix
    logic               dz_q;
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude

    logic               sgn_op, a_neg, b_neg, op_div;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   q_raw, r_raw, fix_hi, fix_lo;

    always_comb begin
        sgn_op = (md_op == OpMult) || (md_op == OpDiv);
        op_div = (md_op == OpDiv) || (md_op == OpDivu);
        a_neg  = sgn_op & a[WIDTH-1];
        b_neg  = sgn_op & b[WIDTH-1];
        abs_a  = a_neg ? -a : a;
        abs_b  = b_neg ? -b : b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        // A set top bit means the trial subtraction went negative: restore.
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        q_raw    = acc_q[WIDTH-1:0];
        r_raw    = acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            // Divide by zero leaves remainder = |a|, so the dividend-sign fix restores raw a.
            fix_lo = dz_q ? '1 : (neg_lo_q ? -q_raw : q_raw);
            fix_hi = neg_hi_q ? -r_raw : r_raw;
        end else begin
            fix_lo = prod_fix[WIDTH-1:0];
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !flush) begin
                        unique case (md_op)
                            OpMult, OpMultu, OpDiv, OpDivu: begin
                                state_q  <= StCalc;
                                busy     <= 1'b1;
                                count_q  <= '0;
                                is_div_q <= op_div;
                                neg_lo_q <= a_neg ^ b_neg;
                                neg_hi_q <= a_neg;
                                dz_q     <= (b == '0);
                                acc_q    <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                                opnd_q   <= op_div ? abs_b : abs_a;
                            end
                            OpMthi:  hi <= a;
                            OpMtlo:  lo <= a;
                            default: ;
                        endcase
                    end
                end
                StCalc: begin
                    if (flush) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        acc_q   <= is_div_q ? div_next : mul_next;
                        count_q <= count_q + 1'b1;
                        if (count_q == CW'(WIDTH - 1)) state_q <= StFix;
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
